mdu_iter_div: RTL

Parametrised iterative restoring divider with signed/unsigned mode, valid/ready handshake, pipeline flush and a pass-through tag. It replaces the vendor divider cores in the multiply/divide unit. One engine serves both DIV and DIVU, and the remainder and quotient feed HI and LO writeback directly. The block is configurable in operand width and tag width, and it defines results for divide-by-zero and signed overflow.

---
 rtl/mdu_iter_div.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mdu_iter_div.sv
// Iterative restoring divider for the MDU: signed/unsigned, one bit per cycle.
// Quotient goes to LO, remainder to HI; divide-by-zero and MIN/-1 are defined.
module mdu_iter_div #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, p_q;
    logic [CW-1:0]    cnt_q;
    logic             q_neg_q, r_neg_q, zero_q;
    logic [TAG_W-1:0] tag_q;

    logic             accept, div_zero, sign_a, sign_b, cnt_last;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   p_sh;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign accept   = in_valid & (state_q == IDLE) & ~flush_i;
    assign div_zero = (in_divisor == '0);
    assign sign_a   = in_signed & in_dividend[WIDTH-1];
    assign sign_b   = in_signed & in_divisor[WIDTH-1];
    assign mag_a    = sign_a ? (WIDTH'(0) - in_dividend) : in_dividend;
    assign mag_b    = sign_b ? (WIDTH'(0) - in_divisor) : in_divisor;
    assign cnt_last = (cnt_q == CW'(WIDTH - 1));

    // Partial remainder stays below the divisor, so the low WIDTH bits
    // of the subtraction are exact whenever it is taken.
    assign p_sh = {p_q, a_q[WIDTH-1]};
    assign ge   = (p_sh >= {1'b0, b_q});
    assign diff = p_sh[WIDTH-1:0] - b_q;

    // On divide-by-zero a_q holds the raw dividend rather than its magnitude.
    assign quot_fix = zero_q  ? '1
                    : q_neg_q ? (WIDTH'(0) - a_q) : a_q;
    assign rem_fix  = zero_q  ? a_q
                    : r_neg_q ? (WIDTH'(0) - p_q) : p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = div_zero ? FIX : CALC;
            CALC: if (cnt_last) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy_o    = 1'b1;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy_o   = 1'b0;
            end
            DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            tag_q   <= '0;
        end else if (accept) begin
            a_q     <= div_zero ? in_dividend : mag_a;
            b_q     <= mag_b;
            p_q     <= '0;
            cnt_q   <= '0;
            q_neg_q <= in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
            r_neg_q <= sign_a;
            zero_q  <= div_zero;
            tag_q   <= in_tag;
        end else if (state_q == CALC) begin
            p_q   <= ge ? diff : p_sh[WIDTH-1:0];
            a_q   <= {a_q[WIDTH-2:0], ge};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_quot <= '0;
            out_rem  <= '0;
            out_tag  <= '0;
        end else if (state_q == FIX && !flush_i) begin
            out_quot <= quot_fix;
            out_rem  <= rem_fix;
            out_tag  <= tag_q;
        end
    end

endmodule
